// File: rtl/nonce_scan_pkg.sv
// rtl/nonce_scan_pkg.sv - types, constants and summary packing shared by the nonce result scanner
package nonce_scan_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        WR0  = 3'd2,
        WR1  = 3'd3,
        DONE = 3'd4
    } scan_state_t;

    // Edges from registering a read address to sampling its data.
    localparam int RD_LAT    = 2;

    localparam int SUMMARY_W = 32;
    localparam int FOUND_BIT = 31;
    localparam int HIT_LSB   = 5;
    localparam int NONCE_LSB = 0;
    localparam int HIT_W     = 6;
    localparam int NONCE_W   = 5;

    // Second summary word: {found, zeros, hit_count, best_nonce}.
    function automatic logic [SUMMARY_W-1:0] pack_summary(
        input logic               found,
        input logic [HIT_W-1:0]   hit_count,
        input logic [NONCE_W-1:0] best_nonce
    );
        logic [SUMMARY_W-1:0] s;
        s                      = '0;
        s[FOUND_BIT]           = found;
        s[HIT_LSB +: HIT_W]    = hit_count;
        s[NONCE_LSB +: NONCE_W] = best_nonce;
        return s;
    endfunction

endpackage

// File: rtl/nonce_scan_cmp.sv
// rtl/nonce_scan_cmp.sv - unsigned comparisons of one captured hash word
//
// Ports:
//   w          - captured hash word
//   best_hash  - running minimum
//   target     - hit threshold
//   is_new_min - w strictly below the running minimum (ties keep the older nonce)
//   is_hit     - w strictly below target
module nonce_scan_cmp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] best_hash,
    input  logic [DATA_W-1:0] target,
    output logic              is_new_min,
    output logic              is_hit
);
    import nonce_scan_pkg::*;

    assign is_new_min = (w < best_hash);
    assign is_hit     = (w < target);

endmodule

// File: rtl/nonce_result_scanner.sv
// rtl/nonce_result_scanner.sv - scans per-nonce hash words for minimum and hits, writes a 2-word summary
//
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   start               - level-sampled start (honoured in IDLE, or in DONE once done is up)
//   result_addr         - address of hash word 0
//   summary_addr        - address of the 2-word summary
//   target              - hit threshold, unsigned
//   done                - scan and summary write complete
//   found, hit_count    - any hit / number of words below target
//   best_nonce, best_hash - index and value of the minimum word
//   mem_*               - single-port synchronous memory, registered address, 2-edge read latency
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] result_addr,
    input  logic [ADDR_W-1:0] summary_addr,
    input  logic [DATA_W-1:0] target,
    output logic              done,
    output logic              found,
    output logic [5:0]        hit_count,
    output logic [4:0]        best_nonce,
    output logic [DATA_W-1:0] best_hash,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    import nonce_scan_pkg::*;

    localparam logic [5:0] N_RC       = 6'(NUM_NONCES);
    localparam logic [4:0] LAST_CC    = 5'(NUM_NONCES - 1);
    localparam logic [1:0] PRIME_LAST = 2'(RD_LAT - 1);

    scan_state_t       state_q, state_d;
    logic [5:0]        rc_q, rc_d;
    logic [4:0]        cc_q, cc_d;
    logic [1:0]        prime_q, prime_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [5:0]        hit_count_q, hit_count_d;
    logic [4:0]        best_nonce_q, best_nonce_d;
    logic [DATA_W-1:0] best_hash_q, best_hash_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;

    logic is_new_min;
    logic is_hit;
    logic begin_scan;

    nonce_scan_cmp #(.DATA_W(DATA_W)) u_cmp (
        .w          (mem_read_data),
        .best_hash  (best_hash_q),
        .target     (target),
        .is_new_min (is_new_min),
        .is_hit     (is_hit)
    );

    // In DONE a restart waits until done has actually been presented for a cycle.
    assign begin_scan = start && ((state_q == IDLE) || ((state_q == DONE) && done_q));

    always_comb begin
        state_d          = state_q;
        rc_d             = rc_q;
        cc_d             = cc_q;
        prime_d          = prime_q;
        done_d           = done_q;
        found_d          = found_q;
        hit_count_d      = hit_count_q;
        best_nonce_d     = best_nonce_q;
        best_hash_d      = best_hash_q;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;

        case (state_q)
            IDLE: ;
            SCAN: begin
                if (rc_q < N_RC) begin
                    mem_addr_d = result_addr + ADDR_W'(rc_q);
                    rc_d       = rc_q + 6'd1;
                end
                // The first SCAN edge only has an address in flight; captures begin after it.
                if (prime_q < PRIME_LAST) begin
                    prime_d = prime_q + 2'd1;
                end else begin
                    if (is_new_min) begin
                        best_hash_d  = mem_read_data;
                        best_nonce_d = cc_q;
                    end
                    hit_count_d = hit_count_q + {5'b0, is_hit};
                    found_d     = (hit_count_d != 6'd0);
                    if (cc_q == LAST_CC) begin
                        state_d = WR0;
                    end else begin
                        cc_d = cc_q + 5'd1;
                    end
                end
            end
            WR0: begin
                mem_we_d         = 1'b1;
                mem_addr_d       = summary_addr;
                mem_write_data_d = best_hash_q;
                state_d          = WR1;
            end
            WR1: begin
                mem_we_d         = 1'b1;
                mem_addr_d       = summary_addr + ADDR_W'(1);
                mem_write_data_d = DATA_W'(pack_summary(found_q, hit_count_q, best_nonce_q));
                state_d          = DONE;
            end
            DONE: begin
                mem_we_d = 1'b0;
                done_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (begin_scan) begin
            state_d      = SCAN;
            mem_addr_d   = result_addr;
            mem_we_d     = 1'b0;
            rc_d         = 6'd1;
            cc_d         = 5'd0;
            prime_d      = 2'd0;
            best_hash_d  = '1;
            best_nonce_d = 5'd0;
            hit_count_d  = 6'd0;
            found_d      = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            rc_q             <= 6'd0;
            cc_q             <= 5'd0;
            prime_q          <= 2'd0;
            done_q           <= 1'b0;
            found_q          <= 1'b0;
            hit_count_q      <= 6'd0;
            best_nonce_q     <= 5'd0;
            best_hash_q      <= '1;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            rc_q             <= rc_d;
            cc_q             <= cc_d;
            prime_q          <= prime_d;
            done_q           <= done_d;
            found_q          <= found_d;
            hit_count_q      <= hit_count_d;
            best_nonce_q     <= best_nonce_d;
            best_hash_q      <= best_hash_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign done           = done_q;
    assign found          = found_q;
    assign hit_count      = hit_count_q;
    assign best_nonce     = best_nonce_q;
    assign best_hash      = best_hash_q;
    assign mem_clk        = clk;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;

endmodule
